// File: rtl/green_dir_select.sv
// green_dir_select: picks the flatter-direction green estimate
// using windowed gradient sums, with a two-stage valid/ready pipe.
module green_dir_select #(
    parameter int pixelBitWidth = 14,
    parameter int WIN           = 4,
    parameter int TIE_MARGIN    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     sol,
    input  logic [pixelBitWidth-1:0] green_h,
    input  logic [pixelBitWidth-1:0] green_v,
    input  logic [pixelBitWidth-2:0] grad_h,
    input  logic [pixelBitWidth-2:0] grad_v,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [pixelBitWidth-1:0] green_out,
    output logic [1:0]               dir_out
);

    localparam int GW = pixelBitWidth - 1;
    localparam int LW = $clog2(WIN);
    localparam int SW = GW + LW;
    localparam int CW = $clog2(WIN + 1);
    localparam int PW = pixelBitWidth;
    localparam logic [SW:0]   MARGIN = (SW+1)'(TIE_MARGIN);
    localparam logic [CW-1:0] FULL   = CW'(WIN);

    logic          stall;
    logic          accept;
    logic [GW-1:0] hist_h [WIN];
    logic [GW-1:0] hist_v [WIN];
    logic [CW-1:0] count;
    logic [SW-1:0] sum_h;
    logic [SW-1:0] sum_v;
    logic          s1_valid;
    logic [PW-1:0] s1_gh;
    logic [PW-1:0] s1_gv;

    logic [GW-1:0] old_h;
    logic [GW-1:0] old_v;
    logic [SW:0]   nxt_h;
    logic [SW:0]   nxt_v;

    logic [SW:0]   cmp_h;
    logic [SW:0]   cmp_v;
    logic [PW:0]   avg_sum;
    logic [PW-1:0] nxt_green;
    logic [1:0]    nxt_dir;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    // Sample leaving the window and the updated running sums
    always_comb begin
        old_h = '0;
        old_v = '0;
        nxt_h = '0;
        nxt_v = '0;
        if (!sol && count == FULL) begin
            old_h = hist_h[WIN-1];
            old_v = hist_v[WIN-1];
        end
        if (sol) begin
            nxt_h = (SW+1)'(grad_h);
            nxt_v = (SW+1)'(grad_v);
        end else begin
            nxt_h = {1'b0, sum_h} + (SW+1)'(grad_h) - (SW+1)'(old_h);
            nxt_v = {1'b0, sum_v} + (SW+1)'(grad_v) - (SW+1)'(old_v);
        end
    end

    // Stage 1: window history, fill count and sums on accepted beats
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_h    <= '0;
            sum_v    <= '0;
            count    <= '0;
            s1_valid <= 1'b0;
            s1_gh    <= '0;
            s1_gv    <= '0;
            for (int i = 0; i < WIN; i++) begin
                hist_h[i] <= '0;
                hist_v[i] <= '0;
            end
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_gh     <= green_h;
                s1_gv     <= green_v;
                sum_h     <= nxt_h[SW-1:0];
                sum_v     <= nxt_v[SW-1:0];
                hist_h[0] <= grad_h;
                hist_v[0] <= grad_v;
                for (int i = 1; i < WIN; i++) begin
                    hist_h[i] <= sol ? '0 : hist_h[i-1];
                    hist_v[i] <= sol ? '0 : hist_v[i-1];
                end
                if (sol)
                    count <= CW'(1);
                else if (count != FULL)
                    count <= count + CW'(1);
            end
        end
    end

    // Direction decision from the registered sums
    always_comb begin
        cmp_h     = {1'b0, sum_h} + MARGIN;
        cmp_v     = {1'b0, sum_v} + MARGIN;
        avg_sum   = {1'b0, s1_gh} + {1'b0, s1_gv};
        nxt_green = avg_sum[PW:1];
        nxt_dir   = 2'b10;
        if (cmp_h < {1'b0, sum_v}) begin
            nxt_green = s1_gh;
            nxt_dir   = 2'b00;
        end else if (cmp_v < {1'b0, sum_h}) begin
            nxt_green = s1_gv;
            nxt_dir   = 2'b01;
        end
    end

    // Stage 2: output register, held while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            green_out <= '0;
            dir_out   <= 2'b00;
        end else if (!stall) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                green_out <= nxt_green;
                dir_out   <= nxt_dir;
            end
        end
    end

endmodule
